mat2_loader: RTL and testbench
==============================

// Module: mat2_loader
// PURPOSE
//  Upstream feeder for the 2x2 determinant datapath. Accepts a stream of signed
//  matrix elements in row-major order (a, b, c, d) over a valid/ready handshake.
//  Packs them into two row words, l1 = {a,b} and l2 = {c,d}, with the first
//  element of each row in the upper byte. Buffers completed matrices in a small
//  FIFO and presents them to the determinant unit over a second valid/ready handshake.
// PARAMETERS
//  ELEM_W  8  width of one signed matrix element; each row word is 2*ELEM_W bits
//  DEPTH   2  number of completed matrices the output FIFO holds (power of 2, >=2)
// PORTS
//  clk        in   1         system clock, all state on rising edge
//  rst        in   1         synchronous reset, active-high
//  in_data    in   ELEM_W    signed element, row-major order a,b,c,d
//  in_valid   in   1         in_data valid
//  in_ready   out  1         loader can accept in_data this cycle
//  flush      in   1         discard the partially assembled matrix; FIFO untouched
//  l1         out  2*ELEM_W  row 0 of head matrix: {a,b}
//  l2         out  2*ELEM_W  row 1 of head matrix: {c,d}
//  out_valid  out  1         l1/l2 hold a complete matrix
//  out_ready  in   1         consumer takes head matrix this cycle
//  level      out  clog2(DEPTH)+1  completed matrices currently in FIFO
//  elem_idx   out  2         next element position expected (0=a,1=b,2=c,3=d)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): elem_idx=0, level=0, out_valid=0, in_ready=1.
//    l1=l2=0. The assembly register is cleared. rst overrides flush and all handshakes.
//  - Input accept: an element is accepted when in_valid && in_ready at the edge.
//    It is written to slot elem_idx, then elem_idx increments mod 4.
//  - Completion: accepting the element at idx 3 pushes {a,b},{c,d} into the FIFO
//    on the same edge. elem_idx returns to 0.
//  - in_ready = !(elem_idx==3 && level==DEPTH). It is a function of registered state only.
//    It never depends combinationally on out_ready.
//  - Simultaneous push and pop when FIFO is full: not possible, because in_ready is low.
//  - Simultaneous push and pop with 0<level<DEPTH: level is unchanged and order is preserved.
//  - Output: out_valid = (level != 0). l1/l2 show the FIFO head (oldest first).
//    When out_valid=0, l1/l2 = 0. Head data stays stable while out_valid && !out_ready.
//  - Pop: out_valid && out_ready at an edge removes the head.
//  - Latency: a matrix is visible on l1/l2 with out_valid=1 in the cycle after its
//    4th element is accepted, if the FIFO was empty.
//  - Throughput: one element per cycle sustained, i.e. one matrix per 4 cycles,
//    when out_ready is held high.
//  - flush: at the edge, elem_idx goes to 0 and the partial slots are cleared.
//    An element presented with in_valid in the flush cycle is dropped and not accepted.
//    in_ready is still evaluated normally. FIFO contents and level are unchanged.
//  - Arithmetic: no arithmetic is done. Elements are copied bit-exact, sign bits included.
//    Packing is l1[2W-1:W]=a, l1[W-1:0]=b, l2[2W-1:W]=c, l2[W-1:0]=d.
//  - FIFO pointers wrap mod DEPTH. level saturates logically at DEPTH, guaranteed by in_ready.
//  - Reset mid-matrix or with the FIFO non-empty: all data is lost. No output pulse
//    appears after reset.
// TESTING
//  1. rst, then in 1,2,3,4 with out_ready=1 -> next cycle l1=16'h0102, l2=16'h0304,
//     out_valid=1; popped the following cycle.
//  2. Signed data -8'sh80,8'h7F,8'hFF,8'h01 -> l1=16'h807F, l2=16'hFF01, bits unaltered.
//  3. out_ready=0, stream 3 matrices (12 elements) -> level reaches 2; in_ready drops
//     at elem_idx=3 and 4th element of matrix 3 is stalled. Raise out_ready -> matrices
//     emerge in order 1,2,3.
//  4. Send a,b, then flush with in_valid=1 carrying 9 -> elem_idx=0, 9 dropped. Next
//     5,6,7,8 -> l1=16'h0506, l2=16'h0708. FIFO level unchanged by flush.
//  5. level=1 with a pop on the same edge as a completing push -> level stays 1,
//     head advances to the new matrix.
//  6. Assert rst with elem_idx=2 and level=2 -> next cycle out_valid=0, level=0,
//     elem_idx=0, l1=l2=0.

Source files
------------

// File: rtl/mat2_loader_if.sv
// mat2_loader_if: element stream in, packed 2x2 matrix rows out
interface mat2_loader_if #(parameter int ELEM_W = 8, parameter int DEPTH = 2);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [ELEM_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic                flush;
  logic [2*ELEM_W-1:0] l1;
  logic [2*ELEM_W-1:0] l2;
  logic                out_valid;
  logic                out_ready;
  logic [LW-1:0]       level;
  logic [1:0]          elem_idx;
  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, l1, l2, out_valid, level, elem_idx
  );
  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, l1, l2, out_valid, level, elem_idx
  );
endinterface

// File: rtl/mat2_loader.sv
// mat2_loader: packs a,b,c,d elements into {a,b},{c,d} rows and queues whole matrices
module mat2_loader #(
  parameter int ELEM_W = 8,
  parameter int DEPTH  = 2
) (
  input logic          clk,
  input logic          rst,
  mat2_loader_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [1:0]          idx_q, idx_d;
  logic [3*ELEM_W-1:0] asm_q, asm_d;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]       level_q, level_d;
  logic [4*ELEM_W-1:0] mem_q [DEPTH];
  logic [4*ELEM_W-1:0] head;
  logic                accept, push, pop, out_valid;
  assign out_valid    = level_q != '0;
  assign bus.in_ready = !(idx_q == 2'd3 && level_q == LW'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign push         = accept && idx_q == 2'd3;
  assign pop          = out_valid && bus.out_ready;
  assign head         = mem_q[rd_q];
  assign bus.out_valid = out_valid;
  assign bus.l1       = out_valid ? head[4*ELEM_W-1:2*ELEM_W] : '0;
  assign bus.l2       = out_valid ? head[2*ELEM_W-1:0] : '0;
  assign bus.level    = level_q;
  assign bus.elem_idx = idx_q;
  // Partial elements shift in, so after a,b,c the register holds {a,b,c}.
  always_comb begin
    idx_d   = bus.flush ? 2'd0 : accept ? idx_q + 2'd1 : idx_q;
    asm_d   = bus.flush ? '0 : accept ? {asm_q[2*ELEM_W-1:0], bus.in_data} : asm_q;
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      asm_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      if (push) mem_q[wr_q] <= {asm_q, bus.in_data};
    end
  end
endmodule

// File: tb/tb_mat2_loader.sv
// tb_mat2_loader: directed checks of packing, FIFO order, stall, flush and reset
module tb_mat2_loader;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  mat2_loader_if #(.ELEM_W(8), .DEPTH(2)) bus ();
  mat2_loader #(.ELEM_W(8), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_elem_idx", 32'(bus.elem_idx), 0);
    chk("rst_l1", 32'(bus.l1), 0);
    chk("rst_l2", 32'(bus.l2), 0);
    bus.out_ready = 1'b1;
    send(8'h01); send(8'h02); send(8'h03);
    chk("t1_idx3", 32'(bus.elem_idx), 3);
    send(8'h04);
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_l1", 32'(bus.l1), 32'h0102);
    chk("t1_l2", 32'(bus.l2), 32'h0304);
    chk("t1_level", 32'(bus.level), 1);
    chk("t1_idx0", 32'(bus.elem_idx), 0);
    tick();
    chk("t1_popped_valid", 32'(bus.out_valid), 0);
    chk("t1_popped_l1", 32'(bus.l1), 0);
    bus.out_ready = 1'b0;
    send(8'h80); send(8'h7F); send(8'hFF); send(8'h01);
    chk("t2_l1", 32'(bus.l1), 32'h807F);
    chk("t2_l2", 32'(bus.l2), 32'hFF01);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t2_level", 32'(bus.level), 0);
    send(8'h11); send(8'h12); send(8'h13); send(8'h14);
    send(8'h21); send(8'h22); send(8'h23); send(8'h24);
    chk("t3_level_full", 32'(bus.level), 2);
    send(8'h31); send(8'h32); send(8'h33);
    chk("t3_in_ready_low", 32'(bus.in_ready), 0);
    send(8'h34);
    chk("t3_stalled_idx", 32'(bus.elem_idx), 3);
    chk("t3_stalled_level", 32'(bus.level), 2);
    chk("t3_head_m1", 32'(bus.l1), 32'h1112);
    chk("t3_head_m1_l2", 32'(bus.l2), 32'h1314);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t3_head_m2", 32'(bus.l1), 32'h2122);
    chk("t3_in_ready_back", 32'(bus.in_ready), 1);
    send(8'h34);
    chk("t3_level_refill", 32'(bus.level), 2);
    chk("t3_head_m2_stable", 32'(bus.l2), 32'h2324);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_head_m3_l1", 32'(bus.l1), 32'h3132);
    chk("t3_head_m3_l2", 32'(bus.l2), 32'h3334);
    tick();
    chk("t3_drained", 32'(bus.level), 0);
    bus.out_ready = 1'b0;
    send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    send(8'hAA); send(8'hBB);
    chk("t4_idx2", 32'(bus.elem_idx), 2);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h09;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t4_flush_idx", 32'(bus.elem_idx), 0);
    chk("t4_flush_level", 32'(bus.level), 1);
    chk("t4_flush_head", 32'(bus.l1), 32'h4142);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    chk("t4_level2", 32'(bus.level), 2);
    bus.out_ready = 1'b1;
    tick();
    chk("t4_l1", 32'(bus.l1), 32'h0506);
    chk("t4_l2", 32'(bus.l2), 32'h0708);
    tick();
    bus.out_ready = 1'b0;
    chk("t4_drained", 32'(bus.level), 0);
    send(8'h51); send(8'h52); send(8'h53); send(8'h54);
    send(8'h61); send(8'h62); send(8'h63);
    bus.out_ready = 1'b1;
    send(8'h64);
    bus.out_ready = 1'b0;
    chk("t5_level", 32'(bus.level), 1);
    chk("t5_l1", 32'(bus.l1), 32'h6162);
    chk("t5_l2", 32'(bus.l2), 32'h6364);
    send(8'h71); send(8'h72); send(8'h73); send(8'h74);
    send(8'h81); send(8'h82);
    chk("t6_pre_level", 32'(bus.level), 2);
    chk("t6_pre_idx", 32'(bus.elem_idx), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_level", 32'(bus.level), 0);
    chk("t6_idx", 32'(bus.elem_idx), 0);
    chk("t6_l1", 32'(bus.l1), 0);
    chk("t6_l2", 32'(bus.l2), 0);
    chk("t6_in_ready", 32'(bus.in_ready), 1);
    tick();
    chk("t6_no_pulse", 32'(bus.out_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
